// File: rtl/dmem_dump_reader_pkg.sv
// Shared types and sizes for the data-memory dump reader, matching the data memory word and address widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_dump_reader_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 8;
  // Output buffer depth. The issue throttle and dump_fifo2 are both built around exactly two slots.
  localparam int FIFO_DEPTH = 2;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  // One bit wider than an address, so a full-memory window (2^ADDR_W words) is representable.
  typedef logic [ADDR_W:0]   cnt_t;

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_RUN,
    DUMP_DONE
  } dump_state_e;

  // One buffered word, tagged with its offset inside the dump window.
  typedef struct packed {
    cnt_t  idx;
    word_t data;
  } dump_ent_t;

endpackage

// File: rtl/dmem_dump_reader_if.sv
// Memory read port plus the output word stream of the dump reader, bundled as one interface.
// Latency: n/a (wiring only); mem_rdata must follow mem_rd_en by exactly one cycle.
// Backpressure: out_valid/out_ready handshake. The memory side has no backpressure.
interface dmem_dump_reader_if;
  import dmem_dump_reader_pkg::*;

  logic  mem_rd_en;
  addr_t mem_addr;
  word_t mem_rdata;

  logic  out_valid;
  logic  out_ready;
  word_t out_data;
  cnt_t  out_index;

  // Dump reader side: drives reads and the stream.
  modport master (
    output mem_rd_en, mem_addr, out_valid, out_data, out_index,
    input  mem_rdata, out_ready
  );

  // Memory and stream sink side.
  modport slave (
    input  mem_rd_en, mem_addr, out_valid, out_data, out_index,
    output mem_rdata, out_ready
  );

endinterface

// File: rtl/dmem_dump_reader_dump_fifo2.sv
// Two-entry synchronous FIFO holding {index, data} words for the dump stream.
// Latency: a word pushed on one edge is visible at the head after that edge.
// Backpressure: a push into a full FIFO is accepted only together with a pop. A pop from an empty FIFO is ignored.
module dump_fifo2
  import dmem_dump_reader_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  dump_ent_t push_ent,
  input  logic      pop,
  output dump_ent_t head,
  output logic      full,
  output logic      empty,
  output logic [1:0] occ
);

  dump_ent_t slot0;
  dump_ent_t slot1;
  logic      wr_ptr;
  logic      rd_ptr;
  logic      push_ok;
  logic      pop_ok;

  assign empty   = (occ == 2'd0);
  assign full    = (occ == 2'd2);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // The head is a register mux only, so there is no path from the write data to the stream outputs.
  assign head    = rd_ptr ? slot1 : slot0;

  // Slot storage, pointers and occupancy. A simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0  <= '0;
      slot1  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push_ok) begin
        if (wr_ptr) slot1 <= push_ent;
        else        slot0 <= push_ent;
        wr_ptr <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(push_ok) - 2'(pop_ok);
    end
  end

endmodule

// File: rtl/dmem_dump_reader.sv
// Data-memory dump engine: on start, stalls the CPU and streams count words from base_addr, tagged with their window offset.
// Latency: first out_valid 2 cycles after the accepted start, then 1 word/cycle while out_ready is high.
// Backpressure: reads are throttled so buffered plus in-flight words never exceed FIFO_DEPTH; no word is dropped.
module dmem_dump_reader
  import dmem_dump_reader_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  addr_t base_addr,
  input  cnt_t  count,
  output logic  busy,
  output logic  done,
  output logic  cpu_stall,
  dmem_dump_reader_if.master bus
);

  dump_state_e state;
  addr_t       base_q;
  cnt_t        cnt_q;
  cnt_t        issued;
  cnt_t        sent;
  logic        inflight;
  cnt_t        inflight_idx;
  logic        issue;
  logic [2:0]  slot_use;

  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [1:0]  fifo_occ;
  dump_ent_t   fifo_head;
  dump_ent_t   push_ent;

  assign fifo_pop = bus.out_valid && bus.out_ready;
  assign push_ent = '{idx: inflight_idx, data: bus.mem_rdata};

  // Issue throttle: count buffered and in-flight words, with a same-cycle pop freeing its slot early.
  always_comb begin
    slot_use = 3'(fifo_occ) + 3'(inflight) - 3'(fifo_pop);
    issue    = (state == DUMP_RUN) && (issued < cnt_q) &&
               (slot_use < 3'(FIFO_DEPTH)) && (!fifo_full || fifo_pop);
  end

  // The window wraps past the top address; truncating the sum to ADDR_W bits does the wrap.
  assign bus.mem_rd_en = issue;
  assign bus.mem_addr  = base_q + issued[ADDR_W-1:0];

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head.data;
  assign bus.out_index = fifo_head.idx;
  assign cpu_stall     = busy;

  // Track the read issued last cycle so its data is pushed with the right window offset.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight     <= 1'b0;
      inflight_idx <= '0;
    end else begin
      inflight     <= issue;
      inflight_idx <= issued;
    end
  end

  // Control FSM: latches the window, counts issued and delivered words, and drives registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DUMP_IDLE;
      base_q <= '0;
      cnt_q  <= '0;
      issued <= '0;
      sent   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        DUMP_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            cnt_q  <= count;
            issued <= '0;
            sent   <= '0;
            if (count == '0) begin
              state <= DUMP_DONE;
              done  <= 1'b1;
            end else begin
              state <= DUMP_RUN;
              busy  <= 1'b1;
            end
          end
        end
        DUMP_RUN: begin
          if (issue) issued <= issued + cnt_t'(1);
          if (fifo_pop) begin
            sent <= sent + cnt_t'(1);
            if (sent == cnt_q - cnt_t'(1)) begin
              state <= DUMP_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        DUMP_DONE: state <= DUMP_IDLE;
        default:   state <= DUMP_IDLE;
      endcase
    end
  end

  dump_fifo2 u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_ent (push_ent),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .occ      (fifo_occ)
  );

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Bench for dmem_dump_reader: a window model built from the memory contents, checked every cycle, plus literal expectations.
// Latency: n/a.
// Backpressure: out_ready is driven either constantly high or from a fixed toggle pattern.
module tb_dmem_dump_reader;
  import dmem_dump_reader_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  start;
  addr_t base_addr;
  cnt_t  count;
  logic  busy;
  logic  done;
  logic  cpu_stall;

  dmem_dump_reader_if bus();

  dmem_dump_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .cpu_stall (cpu_stall),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  word_t dm [256];

  // Model: expected stream and read addresses for the current window.
  word_t exp_data[$];
  cnt_t  exp_idx[$];
  addr_t exp_addr[$];
  // Observed values, kept for the literal checks.
  word_t got_data[$];
  cnt_t  got_idx[$];
  addr_t got_addr[$];

  int   n_rd, n_hs, n_done, n_valid, first_valid, done_cyc, last_start;
  logic mon_en = 1'b0;
  int   rmode = 0;
  int   pidx = 0;
  logic hold_prev = 1'b0;
  word_t prev_data;
  cnt_t  prev_idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic pat_bit(input int p);
    logic [5:0] pat;
    pat = 6'b101001;   // out_ready sequence 1,0,0,1,0,1 read from bit 0 upward
    return pat[p % 6];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read data memory: data appears the cycle after the strobe.
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= dm[bus.mem_addr];

  // Sink readiness, changed just after each edge.
  always @(posedge clk) begin
    #1;
    bus.out_ready = (rmode == 0) ? 1'b1 : pat_bit(pidx);
    pidx++;
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("stall_eq_busy", 64'(cpu_stall), 64'(busy));
      if (bus.mem_rd_en) begin
        n_rd++;
        got_addr.push_back(bus.mem_addr);
        chk("read_in_window", 64'(exp_addr.size() != 0), 64'd1);
        if (exp_addr.size() != 0) chk("read_addr", 64'(bus.mem_addr), 64'(exp_addr.pop_front()));
      end
      if (hold_prev) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_data", 64'(bus.out_data), 64'(prev_data));
        chk("hold_index", 64'(bus.out_index), 64'(prev_idx));
      end
      if (bus.out_valid) begin
        n_valid++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_hs++;
        got_data.push_back(bus.out_data);
        got_idx.push_back(bus.out_index);
        chk("word_in_window", 64'(exp_data.size() != 0), 64'd1);
        if (exp_data.size() != 0) begin
          chk("out_data", 64'(bus.out_data), 64'(exp_data.pop_front()));
          chk("out_index", 64'(bus.out_index), 64'(exp_idx.pop_front()));
        end
      end
      chk("slots_le_2", 64'((n_rd - n_hs) <= 2), 64'd1);
      if (done) begin
        n_done++;
        done_cyc = cyc;
        chk("busy_low_at_done", 64'(busy), 64'd0);
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_idx  = bus.out_index;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},      64'(busy), 64'd0);
    chk({tag, "_done"},      64'(done), 64'd0);
    chk({tag, "_stall"},     64'(cpu_stall), 64'd0);
    chk({tag, "_rd_en"},     64'(bus.mem_rd_en), 64'd0);
    chk({tag, "_addr"},      64'(bus.mem_addr), 64'd0);
    chk({tag, "_valid"},     64'(bus.out_valid), 64'd0);
    chk({tag, "_data"},      64'(bus.out_data), 64'd0);
    chk({tag, "_index"},     64'(bus.out_index), 64'd0);
  endtask

  // Build the model for a window and pulse start; last_start is the cycle number of the edge that took start.
  task automatic arm_dump(input addr_t b, input cnt_t n, input int rm);
    exp_data.delete(); exp_idx.delete(); exp_addr.delete();
    got_data.delete(); got_idx.delete(); got_addr.delete();
    for (int i = 0; i < int'(n); i++) begin
      exp_data.push_back(dm[b + addr_t'(i)]);
      exp_idx.push_back(cnt_t'(i));
      exp_addr.push_back(b + addr_t'(i));
    end
    n_rd = 0; n_hs = 0; n_done = 0; n_valid = 0; first_valid = -1; done_cyc = -1;
    rmode = rm;
    pidx = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; count = n;
    @(posedge clk); #1;
    last_start = cyc;
    start = 1'b0; base_addr = ~b; count = cnt_t'(7);
    if (n != 0) chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic finish_dump(input addr_t b, input cnt_t n, input int dbl_at);
    bit finished;
    finished = 1'b0;
    for (int t = 0; t < 400 && !finished; t++) begin
      if (n_done != 0) finished = 1'b1;
      else begin
        if (t == dbl_at) begin
          start = 1'b1; base_addr = b + 8'h40; count = cnt_t'(3);
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    chk("dump_completes", 64'(finished), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 64'(n_done), 64'd1);
    chk("words_delivered", 64'(n_hs), 64'(n));
    chk("reads_issued", 64'(n_rd), 64'(n));
    chk("model_drained", 64'(exp_data.size()), 64'd0);
    if (n == 0) begin
      chk("zero_done_latency", 64'(done_cyc - last_start), 64'd0);
      chk("zero_no_valid", 64'(n_valid), 64'd0);
    end else begin
      chk("first_valid_latency", 64'(first_valid - last_start), 64'd2);
    end
  endtask

  task automatic run_dump(input addr_t b, input cnt_t n, input int rm, input int dbl_at);
    arm_dump(b, n, rm);
    finish_dump(b, n, dbl_at);
  endtask

  // Hand-computed words of the window base=1, count=4.
  task automatic chk_base_window(input string tag);
    word_t lit [4];
    lit = '{32'hFFFF_FFFF, 32'h3, 32'h2, 32'h1};
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_word"}, 64'(got_data[k]), 64'(lit[k]));
      chk({tag, "_idx"},  64'(got_idx[k]), 64'(k));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
    for (int i = 0; i < 256; i++) dm[i] = 32'hA500_0000 | 32'(i);
    dm[1] = 32'hFFFF_FFFF; dm[2] = 32'h3; dm[3] = 32'h2; dm[4] = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // Basic window, sink always ready: four back-to-back words, done six cycles after the start edge.
    run_dump(8'h01, cnt_t'(4), 0, -1);
    chk_base_window("t1");
    chk("t1_done_latency", 64'(done_cyc - last_start), 64'd6);
    chk("t1_valid_cycles", 64'(n_valid), 64'd4);

    // Same window under the 1,0,0,1,0,1 ready pattern.
    run_dump(8'h01, cnt_t'(4), 1, -1);
    chk_base_window("t2");

    // Empty window.
    run_dump(8'h05, cnt_t'(0), 0, -1);

    // Window wrapping past the top address.
    run_dump(8'hFE, cnt_t'(4), 0, -1);
    chk("t4_addr0", 64'(got_addr[0]), 64'hFE);
    chk("t4_addr1", 64'(got_addr[1]), 64'hFF);
    chk("t4_addr2", 64'(got_addr[2]), 64'h00);
    chk("t4_addr3", 64'(got_addr[3]), 64'h01);
    chk("t4_word0", 64'(got_data[0]), 64'hA500_00FE);
    chk("t4_word2", 64'(got_data[2]), 64'hA500_0000);
    chk("t4_word3", 64'(got_data[3]), 64'hFFFF_FFFF);
    chk("t4_idx3",  64'(got_idx[3]), 64'd3);

    // A second start during the dump must not disturb it.
    run_dump(8'h01, cnt_t'(4), 1, 2);
    chk_base_window("t5");

    // Reset after two words are delivered aborts the dump.
    arm_dump(8'h01, cnt_t'(4), 0);
    for (int t = 0; t < 50 && n_hs < 2; t++) begin
      @(posedge clk); #1;
    end
    chk("t6_two_delivered", 64'(n_hs >= 2), 64'd1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("t6_abort");
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      chk("t6_no_done", 64'(done), 64'd0);
      chk("t6_no_valid", 64'(bus.out_valid), 64'd0);
      chk("t6_no_read", 64'(bus.mem_rd_en), 64'd0);
    end
    mon_en = 1'b1;

    // Fresh dump after the abort starts again from offset 0.
    run_dump(8'h01, cnt_t'(4), 0, -1);
    chk_base_window("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
